blackjack_hand_ctrl: RTL and testbench

BLACKJACK_HAND_CTRL -- requirements
Module: blackjack_hand_ctrl

---
 rtl/blackjack_hand_ctrl_if.sv | 27 ++
 rtl/blackjack_hand_ctrl.sv | 152 +++++++++++++++
 tb/tb_blackjack_hand_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blackjack_hand_ctrl_if.sv
// blackjack_hand_ctrl_if: game control and card-source signals of the blackjack hand controller.
interface blackjack_hand_ctrl_if;
    logic       start_i;
    logic       hit_i;
    logic       stand_i;
    logic [7:0] card_i;
    logic       request_card_o;
    logic [4:0] player_total_o;
    logic [4:0] dealer_total_o;
    logic       player_soft_o;
    logic       busy_o;
    logic [1:0] result_o;
    logic       done_o;
    logic       card_err_o;

    modport slave (
        input  start_i, hit_i, stand_i, card_i,
        output request_card_o, player_total_o, dealer_total_o, player_soft_o,
               busy_o, result_o, done_o, card_err_o
    );

    modport master (
        output start_i, hit_i, stand_i, card_i,
        input  request_card_o, player_total_o, dealer_total_o, player_soft_o,
               busy_o, result_o, done_o, card_err_o
    );
endinterface

// File: rtl/blackjack_hand_ctrl.sv
// blackjack_hand_ctrl: one player vs dealer hand controller with a request/wait/load card fetch.
// Define SOFT17_HIT_EN to make the dealer also draw on a soft total equal to DEALER_STAND.
module blackjack_hand_ctrl #(
    parameter int CARD_LAT     = 2,
    parameter int DEALER_STAND = 17
) (
    input logic                  clk_i,
    input logic                  rst_i,
    blackjack_hand_ctrl_if.slave bus
);
    localparam logic [3:0] LAT_LAST = 4'(CARD_LAT - 1);
    localparam logic [4:0] STAND    = 5'(DEALER_STAND);

    typedef enum logic [2:0] {
        IDLE, DEAL, PLAYER_TURN, DEALER_TURN, RESULT, F_REQ, F_WAIT, F_LOAD
    } state_t;

    state_t     state_q, state_d, ret_q, ret_d;
    logic       tgt_q, tgt_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] deal_q, deal_d;
    logic [4:0] p_hard_q, p_hard_d, d_hard_q, d_hard_d;
    logic       p_ace_q, p_ace_d, d_ace_q, d_ace_d;
    logic [1:0] result_q, result_d;
    logic       err_q, err_d;

    logic [3:0] rank;
    logic [4:0] val, p_best, d_best;
    logic       bad, ace, p_soft, d_soft, d_draw, unused_card;

    assign rank        = bus.card_i[3:0];
    assign bad         = rank == 4'd0 || rank > 4'd13;
    assign ace         = rank == 4'd1;
    assign val         = (bad || rank > 4'd10) ? 5'd10 : {1'b0, rank};
    assign unused_card = ^bus.card_i[7:4];

    // An ace is promoted to 11 only while the hard sum leaves room for it.
    assign p_soft = p_ace_q && p_hard_q <= 5'd11;
    assign d_soft = d_ace_q && d_hard_q <= 5'd11;
    assign p_best = p_soft ? p_hard_q + 5'd10 : p_hard_q;
    assign d_best = d_soft ? d_hard_q + 5'd10 : d_hard_q;
`ifdef SOFT17_HIT_EN
    assign d_draw = d_best < STAND || (d_best == STAND && d_soft);
`else
    assign d_draw = d_best < STAND;
`endif

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        deal_d   = deal_q;
        p_hard_d = p_hard_q;
        p_ace_d  = p_ace_q;
        d_hard_d = d_hard_q;
        d_ace_d  = d_ace_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE, RESULT: if (bus.start_i) begin
                state_d  = DEAL;
                deal_d   = 3'd0;
                p_hard_d = 5'd0;
                p_ace_d  = 1'b0;
                d_hard_d = 5'd0;
                d_ace_d  = 1'b0;
                result_d = 2'b00;
                err_d    = 1'b0;
            end
            DEAL: if (deal_q == 3'd4) state_d = PLAYER_TURN;
            else begin
                tgt_d   = deal_q[0];
                deal_d  = deal_q + 3'd1;
                ret_d   = DEAL;
                state_d = F_REQ;
            end
            PLAYER_TURN: if (p_best > 5'd21) begin
                result_d = 2'b10;
                state_d  = RESULT;
            end else if (p_best == 5'd21 || bus.stand_i) state_d = DEALER_TURN;
            else if (bus.hit_i) begin
                tgt_d   = 1'b0;
                ret_d   = PLAYER_TURN;
                state_d = F_REQ;
            end
            DEALER_TURN: if (d_draw) begin
                tgt_d   = 1'b1;
                ret_d   = DEALER_TURN;
                state_d = F_REQ;
            end else begin
                state_d  = RESULT;
                result_d = (d_best > 5'd21 || p_best > d_best) ? 2'b01 :
                           (d_best > p_best) ? 2'b10 : 2'b11;
            end
            F_REQ: begin
                cnt_d   = 4'd0;
                state_d = F_WAIT;
            end
            F_WAIT: if (cnt_q == LAT_LAST) begin
                cnt_d   = 4'd0;
                state_d = F_LOAD;
            end else cnt_d = cnt_q + 4'd1;
            F_LOAD: begin
                state_d  = ret_q;
                err_d    = err_q | bad;
                p_hard_d = tgt_q ? p_hard_q : p_hard_q + val;
                p_ace_d  = p_ace_q | (~tgt_q & ace);
                d_hard_d = tgt_q ? d_hard_q + val : d_hard_q;
                d_ace_d  = d_ace_q | (tgt_q & ace);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            ret_q    <= IDLE;
            tgt_q    <= 1'b0;
            cnt_q    <= 4'd0;
            deal_q   <= 3'd0;
            p_hard_q <= 5'd0;
            p_ace_q  <= 1'b0;
            d_hard_q <= 5'd0;
            d_ace_q  <= 1'b0;
            result_q <= 2'b00;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            tgt_q    <= tgt_d;
            cnt_q    <= cnt_d;
            deal_q   <= deal_d;
            p_hard_q <= p_hard_d;
            p_ace_q  <= p_ace_d;
            d_hard_q <= d_hard_d;
            d_ace_q  <= d_ace_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.request_card_o = state_q == F_REQ;
    assign bus.player_total_o = p_best;
    assign bus.dealer_total_o = d_best;
    assign bus.player_soft_o  = p_soft;
    assign bus.busy_o         = !(state_q == IDLE || state_q == RESULT);
    assign bus.done_o         = state_q == RESULT;
    assign bus.result_o       = result_q;
    assign bus.card_err_o     = err_q;
endmodule

// File: tb/tb_blackjack_hand_ctrl.sv
// tb_blackjack_hand_ctrl: randomized games against a card-list model of blackjack rules,
// plus scripted hands and mid-game resets.
module tb_blackjack_hand_ctrl;
    localparam int LAT   = 2;
    localparam int STAND = 17;
`ifdef SOFT17_HIT_EN
    localparam bit S17 = 1'b1;
`else
    localparam bit S17 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    blackjack_hand_ctrl_if bus();
    blackjack_hand_ctrl #(.CARD_LAT(LAT), .DEALER_STAND(STAND)) dut (
        .clk_i(clk), .rst_i(rst_i), .bus(bus)
    );
    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int hv[2][32];
    int hn[2];
    bit err_m, stood, chk_en;
    int hits, gen, req_cnt;
    logic [7:0] deck[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int val_of(input logic [3:0] r);
        return r == 4'd1 ? 1 : (r >= 4'd2 && r <= 4'd10) ? int'(r) : 10;
    endfunction

    function automatic int raw_of(input int h);
        int s = 0;
        for (int i = 0; i < hn[h]; i++) s += hv[h][i];
        return s;
    endfunction

    // Best total: the largest sum <= 21 over all ways of counting aces as 1 or 11.
    function automatic int best_of(input int h);
        int s, a, b;
        s = raw_of(h);
        a = 0;
        for (int i = 0; i < hn[h]; i++) if (hv[h][i] == 1) a++;
        b = s;
        for (int k = 1; k <= a; k++) if (s + 10 * k <= 21) b = s + 10 * k;
        return b;
    endfunction

    function automatic bit soft_of(input int h);
        return best_of(h) != raw_of(h);
    endfunction

    function automatic bit dealer_should_draw();
        int b;
        b = best_of(1);
        return b < STAND || (S17 && b == STAND && soft_of(1));
    endfunction

    function automatic int result_of();
        int pb, db;
        pb = best_of(0);
        db = best_of(1);
        if (pb > 21) return 2;
        if (db > 21 || pb > db) return 1;
        if (db > pb) return 2;
        return 3;
    endfunction

    function automatic logic [7:0] mk(input int r);
        return {2'($urandom), 2'($urandom), 4'(r)};
    endfunction

    task automatic model_clear();
        hn[0] = 0;
        hn[1] = 0;
        err_m = 1'b0;
        stood = 1'b0;
        hits = 0;
        req_cnt = 0;
    endtask

    task automatic model_add(input logic [7:0] c);
        int n, h;
        n = hn[0] + hn[1];
        h = n < 4 ? n % 2 : ((stood || best_of(0) >= 21) ? 1 : 0);
        if (n >= 4) begin
            if (h == 1) chk("dealer_draw_rule", int'(dealer_should_draw() && best_of(0) <= 21), 1);
            else chk("player_hit_granted", int'(hits > hn[0] - 2), 1);
        end
        if (hn[h] < 32) begin
            hv[h][hn[h]] = val_of(c[3:0]);
            hn[h]++;
        end
        if (c[3:0] == 4'd0 || c[3:0] > 4'd13) err_m = 1'b1;
    endtask

    always @(negedge rst_i) gen++;

    // Card source: garbage except in the one cycle the card must be sampled.
    task automatic fetch();
        logic [7:0] c, g;
        int g0;
        g0 = gen;
        req_cnt++;
        chk("deck_has_card", int'(deck.size() > 0), 1);
        if (deck.size() > 0) c = deck.pop_front();
        else c = mk(5);
        g = {2'($urandom), 2'($urandom), (val_of(c[3:0]) >= 6 ? 4'd2 : 4'd10)};
        bus.card_i = g;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == LAT + 1 && gen == g0) bus.card_i = c;
            @(negedge clk);
            if (gen == g0 && rst_i) chk("req_single_pulse", int'(bus.request_card_o), 0);
        end
        @(posedge clk);
        #1;
        bus.card_i = g;
        if (gen == g0 && rst_i) model_add(c);
    endtask

    initial begin
        bus.card_i = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_i && bus.request_card_o) fetch();
        end
    end

    always @(negedge clk) if (rst_i && chk_en) begin
        chk("player_total", int'(bus.player_total_o), best_of(0));
        chk("dealer_total", int'(bus.dealer_total_o), best_of(1));
        chk("player_soft", int'(bus.player_soft_o), int'(soft_of(0)));
        chk("card_err", int'(bus.card_err_o), int'(err_m));
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, int'(bus.request_card_o), 0);
        chk({tag, "_ptotal"}, int'(bus.player_total_o), 0);
        chk({tag, "_dtotal"}, int'(bus.dealer_total_o), 0);
        chk({tag, "_soft"}, int'(bus.player_soft_o), 0);
        chk({tag, "_busy"}, int'(bus.busy_o), 0);
        chk({tag, "_result"}, int'(bus.result_o), 0);
        chk({tag, "_done"}, int'(bus.done_o), 0);
        chk({tag, "_err"}, int'(bus.card_err_o), 0);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        model_clear();
    endtask

    // strat: 0 random, 1 stand, 2 always hit, 3 hit and stand together
    task automatic play_game(input int strat);
        int r, n0;
        start_pulse();
        @(negedge clk);
        chk("start_busy", int'(bus.busy_o), 1);
        chk("start_done", int'(bus.done_o), 0);
        chk("start_result", int'(bus.result_o), 0);
        chk("start_err", int'(bus.card_err_o), 0);
        for (int i = 0; i < 400 && hn[0] + hn[1] < 4; i++) @(negedge clk);
        chk("deal_four_cards", hn[0] + hn[1], 4);
        while (best_of(0) < 21 && !stood) begin
            r = strat == 0 ? int'($urandom_range(1, 3)) : strat;
            if (strat == 0 && best_of(0) < 12) r = 2;
            if (r == 2) begin
                n0 = hn[0];
                bus.hit_i = 1'b1;
                for (int i = 0; i < 100 && !bus.request_card_o; i++) @(negedge clk);
                bus.hit_i = 1'b0;
                chk("hit_requests_card", int'(bus.request_card_o), 1);
                if (!bus.request_card_o) break;
                hits++;
                for (int i = 0; i < 100 && hn[0] == n0; i++) @(negedge clk);
                chk("hit_card_loaded", hn[0], n0 + 1);
            end else begin
                stood = 1'b1;
                bus.stand_i = 1'b1;
                bus.hit_i = r == 3;
                for (int i = 0; i < 100 && !bus.done_o && !bus.request_card_o; i++) @(negedge clk);
                bus.stand_i = 1'b0;
                bus.hit_i = 1'b0;
            end
        end
        for (int i = 0; i < 600 && !bus.done_o; i++) @(negedge clk);
        chk("game_done", int'(bus.done_o), 1);
        chk("result", int'(bus.result_o), result_of());
        chk("idle_busy", int'(bus.busy_o), 0);
        chk("player_cards", hn[0], 2 + hits);
        if (best_of(0) > 21) chk("no_dealer_draw_on_bust", hn[1], 2);
        else chk("dealer_stopped", int'(dealer_should_draw()), 0);
        repeat (3) begin
            @(negedge clk);
            chk("no_req_after_done", int'(bus.request_card_o), 0);
        end
    endtask

    task automatic reset_now(input string tag);
        rst_i = 1'b0;
        #1;
        deck.delete();
        model_clear();
        check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        check_reset_outputs({tag, "_held"});
        rst_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk({tag, "_idle_req"}, int'(bus.request_card_o), 0);
            chk({tag, "_idle_busy"}, int'(bus.busy_o), 0);
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.hit_i = 1'b0;
        bus.stand_i = 1'b0;
        chk_en = 1'b0;
        gen = 0;
        model_clear();
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        chk_en = 1'b1;

        // 10,7,A,9: player soft 21, dealer 16 draws 5 to 21 -> push
        deck = '{mk(10), mk(7), mk(1), mk(9), mk(5)};
        play_game(1);
        chk("t34_player", int'(bus.player_total_o), 21);
        chk("t34_soft", int'(bus.player_soft_o), 1);
        chk("t34_dealer", int'(bus.dealer_total_o), 21);
        chk("t34_result", int'(bus.result_o), 3);

        // player 16 hits a king -> 26 bust, dealer untouched
        deck = '{mk(10), mk(9), mk(6), mk(8), mk(13)};
        play_game(2);
        chk("t35_player", int'(bus.player_total_o), 26);
        chk("t35_dealer", int'(bus.dealer_total_o), 17);
        chk("t35_result", int'(bus.result_o), 2);
        chk("t35_requests", req_cnt, 5);

        // dealer soft 17 against player 18
        deck = '{mk(9), mk(1), mk(9), mk(6), mk(2)};
        play_game(1);
        chk("t36_player", int'(bus.player_total_o), 18);
        chk("t36_dealer", int'(bus.dealer_total_o), S17 ? 19 : 17);
        chk("t36_result", int'(bus.result_o), S17 ? 2 : 1);
        chk("t36_requests", req_cnt, S17 ? 5 : 4);

        // hit and stand together: stand wins, no card for the player
        deck = '{mk(10), mk(7), mk(5), mk(10)};
        play_game(3);
        chk("t37_requests", req_cnt, 4);
        chk("t37_player", int'(bus.player_total_o), 15);
        chk("t37_result", int'(bus.result_o), 2);

        // rank 14 in the deal counts as 10 and latches the error flag
        deck = '{mk(2), mk(14), mk(3), mk(5), mk(10)};
        play_game(1);
        chk("t39_err", int'(bus.card_err_o), 1);
        chk("t39_dealer", int'(bus.dealer_total_o), 25);
        chk("t39_result", int'(bus.result_o), 1);

        // reset one cycle after the first request pulse
        deck = '{mk(10), mk(7), mk(5), mk(10)};
        start_pulse();
        for (int i = 0; i < 50 && !bus.request_card_o; i++) @(negedge clk);
        chk("t38_first_req", int'(bus.request_card_o), 1);
        @(posedge clk);
        #2;
        reset_now("t38");

        // reset during a hit fetch with loaded hands and the error flag set
        deck = '{mk(14), mk(14), mk(5), mk(6), mk(3)};
        start_pulse();
        for (int i = 0; i < 400 && hn[0] + hn[1] < 4; i++) @(negedge clk);
        chk("rb_player_pre", int'(bus.player_total_o), 15);
        chk("rb_err_pre", int'(bus.card_err_o), 1);
        bus.hit_i = 1'b1;
        for (int i = 0; i < 100 && !bus.request_card_o; i++) @(negedge clk);
        bus.hit_i = 1'b0;
        chk("rb_hit_req", int'(bus.request_card_o), 1);
        @(posedge clk);
        #3;
        reset_now("rb");

        repeat (150) begin
            int r;
            deck.delete();
            repeat (24) begin
                r = int'($urandom_range(0, 41));
                deck.push_back(mk(r < 39 ? 1 + r % 13 : (r == 39 ? 0 : (r == 40 ? 14 : 15))));
            end
            play_game(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #900000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
